signal_avg_peak: RTL and testbench
==================================

# signal_avg_peak

Parametrised EMAT record averager and gated peak extractor. Accumulates 2^avg_log2 consecutive records of ADC samples into an internal accumulator RAM, then streams the averaged record out over a valid/ready interface toward the ARM result FIFO. While streaming, it extracts the maximum value and its index inside a programmable gate, replacing the fixed dead-zone and 3000-sample limits. Sits between the high-pass filter and the result FIFO in the signal-processing path.

## Interface
- DATA_W, 10, sample width (unsigned)
- REC_LEN, 8192, samples per record
- IDX_W, $clog2(REC_LEN), index width
- AVG_MAX_LOG2, 7, max log2 of averaged record count
- ACC_W, DATA_W+AVG_MAX_LOG2, accumulator width
- clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort; returns to IDLE from any state
- arm  in  1  start-acquisition pulse; honoured in IDLE and DONE only
- avg_log2  in  3  records to average = 2^min(avg_log2, AVG_MAX_LOG2); sampled at arm
- gate_lo, gate_hi  in  IDX_W each  inclusive peak gate; sampled at arm
- din  in  DATA_W  sample
- din_valid  in  1  per-sample strobe
- dout  out  DATA_W  averaged sample
- dout_valid  out  1  dout valid
- dout_ready  in  1  consumer accepts
- peak_value  out  DATA_W  gated maximum
- peak_index  out  IDX_W  index of maximum
- peak_hit  out  1  at least one index fell in gate
- busy  out  1  state is ACQ or DUMP
- done  out  1  results valid; held in DONE

## Operation
- States: IDLE, ACQ, DUMP, DONE. Reset → IDLE.
- IDLE/DONE + arm → ACQ; captures avg_log2 (clamped), gate_lo, gate_hi; clears done, sample index, record counter.
- ACQ: each din_valid sample at index i: first record writes acc[i]=din (zero-extended); later records write acc[i]+=din. Index wraps 0 after REC_LEN-1, record counter increments. After the last sample of record 2^avg_log2 → DUMP. Samples before arm or outside ACQ ignored.
- DUMP: reads acc[0..REC_LEN-1] in order; dout = acc[i] >> avg_log2, truncated, low DATA_W bits. Each dout handshake (valid & ready) with gate_lo ≤ i ≤ gate_hi updates peak when dout > peak_value (strict; first occurrence wins on ties), and sets peak_hit. After handshake of index REC_LEN-1 → DONE.
- DONE: done=1, peak outputs stable until next arm/clr/reset.
- Empty gate (gate_lo > gate_hi or gate_lo ≥ REC_LEN): peak_value=0, peak_index=0, peak_hit=0.
- clr in any state: → IDLE next cycle; dout_valid, busy, done, peak_* cleared; RAM contents don't-care (first record overwrites).
- clr and arm same cycle: clr wins.

## Timing
- Reset values: dout=0, dout_valid=0, peak_value=0, peak_index=0, peak_hit=0, busy=0, done=0.
- Accumulate: read-modify-write, write lands 2 cycles after sample; full-rate back-to-back din_valid supported (sequential indices, no hazard; write at REC_LEN-1 completes before the next record reads index 0).
- DUMP: first dout_valid 2 cycles after entering DUMP (1-cycle RAM read + output register). dout held stable while dout_valid & !dout_ready; 1 sample/cycle at dout_ready=1 (skid buffer, no bubbles, no drops, no duplicates).
- done and final peak_* asserted 1 cycle after the last dout handshake.
- busy rises cycle after arm, falls on entering DONE.

## Configuration
- RECTIFY_EN defined: din treated as offset-binary about 2^(DATA_W-1); accumulated value is |din − 2^(DATA_W-1)| (half-wave/thickness mode uses full-wave rectification); dout and peak operate on rectified averages.
- Undefined: raw din accumulated unchanged.

## Structure
- Shared package sigpro_pkg: state enum (IDLE, ACQ, DUMP, DONE), default DATA_W/REC_LEN/AVG_MAX_LOG2 constants.
- One sub-module: avg_acc_ram — simple dual-port RAM, REC_LEN × ACC_W, registered 1-cycle read, one write port.

## Test plan
- REC_LEN=16, avg_log2=0, ramp 0..15, gate [4,10] → dout 0..15, peak_value=10, peak_index=10, peak_hit=1, done=1.
- avg_log2=2, four records constant 5,6,7,8 → every dout=6 (26>>2).
- avg_log2=7, 128 records of 1023 → dout=1023, no overflow.
- dout_ready random 50% → output sequence identical to ready=1 run; dout stable during stalls.
- Value 9 at indices 5 and 7, gate [0,15] → peak_index=5; gate_lo=12, gate_hi=3 → peak_hit=0, peak_value=0.
- clr mid-DUMP and reset_n low mid-ACQ → IDLE, busy=0, dout_valid=0 next cycle; re-arm gives correct results.

Source files
------------

// File: rtl/sigpro_pkg.sv
// Shared signal-processing definitions: averager/peak FSM states and default sizes.
package sigpro_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_DATA_W       = 10;
  localparam int DEF_REC_LEN      = 8192;
  localparam int DEF_AVG_MAX_LOG2 = 7;

endpackage

// File: rtl/avg_acc_ram.sv
// Accumulator RAM: simple dual-port, one write port, registered 1-cycle read.
module avg_acc_ram
  import sigpro_pkg::*;
#(
  parameter int DEPTH = DEF_REC_LEN,
  parameter int WIDTH = DEF_DATA_W + DEF_AVG_MAX_LOG2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read data holds when re is low so the dump pipeline can stall on it.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/signal_avg_peak.sv
// Record averager with gated peak extractor feeding the result FIFO.
// Define RECTIFY_EN to accumulate |din - 2^(DATA_W-1)| instead of raw din.
module signal_avg_peak
  import sigpro_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int REC_LEN      = DEF_REC_LEN,
  parameter int IDX_W        = $clog2(REC_LEN),
  parameter int AVG_MAX_LOG2 = DEF_AVG_MAX_LOG2,
  parameter int ACC_W        = DATA_W + AVG_MAX_LOG2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              arm,
  input  logic [2:0]        avg_log2,
  input  logic [IDX_W-1:0]  gate_lo,
  input  logic [IDX_W-1:0]  gate_hi,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] peak_value,
  output logic [IDX_W-1:0]  peak_index,
  output logic              peak_hit,
  output logic              busy,
  output logic              done,
  output state_t            state_dbg
);

  // Output handshake: a sample transfers on a cycle where dout_valid && dout_ready;
  // while dout_valid is high and dout_ready low, dout is held unchanged.

  localparam int REC_W = AVG_MAX_LOG2 + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_LEN - 1);

  state_t state_q, state_d;

  logic [2:0]       sh_q, sh_in;
  logic [IDX_W-1:0] gate_lo_q, gate_hi_q;
  logic [IDX_W-1:0] idx_q;
  logic [REC_W-1:0] rec_q, rec_last_val;

  logic              arm_fire, sample_fire, acq_end;
  logic [DATA_W-1:0] din_x;

  logic              s1_valid, s1_first;
  logic [IDX_W-1:0]  s1_idx;
  logic [DATA_W-1:0] s1_data;

  logic              ram_we, ram_re;
  logic [IDX_W-1:0]  ram_ra;
  logic [ACC_W-1:0]  ram_wd, ram_rd;

  logic [IDX_W-1:0]  rd_ptr, r_idx, o_idx;
  logic              rd_done, r_valid, o_free, dump_re, hs, in_gate;

  assign sh_in = ({1'b0, avg_log2} > 4'(AVG_MAX_LOG2)) ? 3'(AVG_MAX_LOG2) : avg_log2;
  assign rec_last_val = REC_W'((1 << sh_q) - 1);

  assign arm_fire    = arm && !clr && (state_q == IDLE || state_q == DONE);
  assign sample_fire = (state_q == ACQ) && din_valid && !clr;
  assign acq_end     = sample_fire && (idx_q == LAST_IDX) && (rec_q == rec_last_val);

`ifdef RECTIFY_EN
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
  assign din_x = (din >= MID) ? (din - MID) : (MID - din);
`else
  assign din_x = din;
`endif

  assign o_free  = !dout_valid || dout_ready;
  assign hs      = dout_valid && dout_ready;
  assign in_gate = (o_idx >= gate_lo_q) && (o_idx <= gate_hi_q);
  assign dump_re = (state_q == DUMP) && !rd_done && (!r_valid || o_free) && !clr;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (arm) state_d = ACQ;
        ACQ:        if (acq_end) state_d = DUMP;
        DUMP:       if (hs && o_idx == LAST_IDX) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q      <= '0;
      gate_lo_q <= '0;
      gate_hi_q <= '0;
      idx_q     <= '0;
      rec_q     <= '0;
    end else if (arm_fire) begin
      sh_q      <= sh_in;
      gate_lo_q <= gate_lo;
      gate_hi_q <= gate_hi;
      idx_q     <= '0;
      rec_q     <= '0;
    end else if (sample_fire) begin
      if (idx_q == LAST_IDX) begin
        idx_q <= '0;
        rec_q <= rec_q + 1'b1;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Read at the sample edge, write one edge later; consecutive indices never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_idx   <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= sample_fire;
      if (sample_fire) begin
        s1_first <= (rec_q == '0);
        s1_idx   <= idx_q;
        s1_data  <= din_x;
      end
    end
  end

  assign ram_we = s1_valid;
  assign ram_wd = s1_first ? ACC_W'(s1_data) : ram_rd + ACC_W'(s1_data);
  assign ram_re = sample_fire || dump_re;
  assign ram_ra = (state_q == DUMP) ? rd_ptr : idx_q;

  avg_acc_ram #(
    .DEPTH (REC_LEN),
    .WIDTH (ACC_W),
    .AW    (IDX_W)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .wa  (s1_idx),
    .wd  (ram_wd),
    .re  (ram_re),
    .ra  (ram_ra),
    .rd  (ram_rd)
  );

  // Two-stage dump pipeline: RAM read register (r_*) then output register (dout).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      rd_done    <= 1'b0;
      r_valid    <= 1'b0;
      r_idx      <= '0;
      o_idx      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (clr || state_q != DUMP) begin
      rd_ptr     <= '0;
      rd_done    <= 1'b0;
      r_valid    <= 1'b0;
      dout_valid <= 1'b0;
      if (clr) dout <= '0;
    end else begin
      if (dump_re) begin
        rd_ptr <= rd_ptr + 1'b1;
        r_idx  <= rd_ptr;
        if (rd_ptr == LAST_IDX) rd_done <= 1'b1;
      end
      if (o_free) begin
        dout_valid <= r_valid;
        if (r_valid) begin
          dout  <= DATA_W'(ram_rd >> sh_q);
          o_idx <= r_idx;
        end
      end
      r_valid <= dump_re || (r_valid && !o_free);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_value <= '0;
      peak_index <= '0;
      peak_hit   <= 1'b0;
    end else if (clr || arm_fire) begin
      peak_value <= '0;
      peak_index <= '0;
      peak_hit   <= 1'b0;
    end else if (hs && in_gate) begin
      peak_hit <= 1'b1;
      if (dout > peak_value) begin
        peak_value <= dout;
        peak_index <= o_idx;
      end
    end
  end

  assign busy      = (state_q == ACQ) || (state_q == DUMP);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_signal_avg_peak.sv
// Directed bench for signal_avg_peak at REC_LEN=16 with a queue-based averaging/peak model.
module tb_signal_avg_peak;
  import sigpro_pkg::*;

  localparam int DW = 10;
  localparam int RL = 16;
  localparam int IW = 4;
  localparam int AM = 7;

  logic          clk, reset_n, clr, arm, din_valid, dout_valid, dout_ready;
  logic [2:0]    avg_log2;
  logic [IW-1:0] gate_lo, gate_hi, peak_index;
  logic [DW-1:0] din, dout, peak_value;
  logic          peak_hit, busy, done;
  state_t        state_dbg;

  signal_avg_peak #(.DATA_W(DW), .REC_LEN(RL), .AVG_MAX_LOG2(AM)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .arm(arm), .avg_log2(avg_log2),
    .gate_lo(gate_lo), .gate_hi(gate_hi), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .peak_value(peak_value), .peak_index(peak_index), .peak_hit(peak_hit),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  int rec_data[128][RL];
  int exp_rec[RL];
  bit chk_en = 0;
  bit rnd_ready = 0;
  bit expect_done_next = 0;
  int out_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n = 1'b0; clr = 1'b0; arm = 1'b0; din_valid = 1'b0; din = '0;
    avg_log2 = '0; gate_lo = '0; gate_hi = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // scoreboard: every output handshake checked against the model queue
  initial begin
    logic [DW-1:0] last_dout;
    bit last_stall;
    last_stall = 0;
    last_dout = '0;
    forever begin
      @(negedge clk);
      if (expect_done_next) begin
        check("done_after_last", int'(done), 1);
        expect_done_next = 0;
      end
      if (chk_en) begin
        if (last_stall) begin
          check("stall_valid", int'(dout_valid), 1);
          check("stall_hold", int'(dout), int'(last_dout));
        end
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) check("extra_output", 1, 0);
          else begin
            check($sformatf("dout[%0d]", out_cnt), int'(dout), int'(exp_q.pop_front()));
            out_cnt++;
            if (out_cnt == RL) expect_done_next = 1;
          end
        end
      end
      last_stall = chk_en && dout_valid && !dout_ready;
      last_dout = dout;
    end
  end

  // driver tasks (called at posedge+1)
  task automatic pulse_arm(input int n, input int lo, input int hi);
    avg_log2 = 3'(n); gate_lo = IW'(lo); gate_hi = IW'(hi); arm = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
    check("busy_after_arm", int'(busy), 1);
    check("done_clear_arm", int'(done), 0);
  endtask

  task automatic send_rec(input int r, input bit gaps);
    for (int i = 0; i < RL; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        din_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      din = DW'(rec_data[r][i]);
      din_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
  endtask

  function automatic int rect(input int v);
`ifdef RECTIFY_EN
    return (v >= 512) ? v - 512 : 512 - v;
`else
    return v;
`endif
  endfunction

  // model: mean of 2^n records per index, then strict-greater scan of the gate
  task automatic build_model(input int n, input int lo, input int hi,
                             output int pv, output int pi, output int ph);
    for (int i = 0; i < RL; i++) begin
      int sum;
      sum = 0;
      for (int r = 0; r < (1 << n); r++) sum += rect(rec_data[r][i]);
      exp_rec[i] = (sum >> n) % (1 << DW);
      exp_q.push_back(DW'(exp_rec[i]));
    end
    pv = 0; pi = 0; ph = 0;
    for (int i = lo; i <= hi; i++) begin
      ph = 1;
      if (exp_rec[i] > pv) begin
        pv = exp_rec[i];
        pi = i;
      end
    end
  endtask

  task automatic acquire(input string tag, input int n, input int lo, input int hi,
                         input bit rr, input bit gaps);
    int pv, pi, ph, cyc;
    exp_q.delete();
    out_cnt = 0;
    build_model(n, lo, hi, pv, pi, ph);
    pulse_arm(n, lo, hi);
    chk_en = 1;
    rnd_ready = rr;
    for (int r = 0; r < (1 << n); r++) send_rec(r, gaps);
    @(negedge clk);
    check({tag, " lat0"}, int'(dout_valid), 0);
    check({tag, " busy_dump"}, int'(busy), 1);
    @(negedge clk);
    check({tag, " lat1"}, int'(dout_valid), 0);
    @(negedge clk);
    check({tag, " lat2"}, int'(dout_valid), 1);
    cyc = 0;
    while (!done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " done_timeout"}, int'(done), 1);
    @(negedge clk);
    check({tag, " peak_value"}, int'(peak_value), pv);
    check({tag, " peak_index"}, int'(peak_index), pi);
    check({tag, " peak_hit"}, int'(peak_hit), ph);
    check({tag, " busy_done"}, int'(busy), 0);
    check({tag, " valid_done"}, int'(dout_valid), 0);
    check({tag, " leftover"}, exp_q.size(), 0);
    chk_en = 0;
    rnd_ready = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst dout", int'(dout), 0);
    check("rst dout_valid", int'(dout_valid), 0);
    check("rst peak_value", int'(peak_value), 0);
    check("rst peak_index", int'(peak_index), 0);
    check("rst peak_hit", int'(peak_hit), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    @(posedge clk);
    #1;

    // samples in IDLE must be ignored
    din = 10'd1000; din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 din_valid = 1'b0;
    check("idle_ignore busy", int'(busy), 0);

    for (int i = 0; i < RL; i++) rec_data[0][i] = i;
    acquire("ramp", 0, 4, 10, 0, 0);
    check("pin ramp peak_value", int'(peak_value), 10);
    check("pin ramp peak_index", int'(peak_index), 10);
    check("pin ramp done", int'(done), 1);

    for (int r = 0; r < 4; r++)
      for (int i = 0; i < RL; i++) rec_data[r][i] = 5 + r;
    acquire("avg4", 2, 0, 15, 0, 1);
    check("pin avg4 model", exp_rec[3], 6);
    check("pin avg4 dout", int'(dout), 6);

    for (int r = 0; r < 128; r++)
      for (int i = 0; i < RL; i++) rec_data[r][i] = 1023;
    acquire("avg128", 7, 0, 15, 1, 0);
    check("pin avg128 dout", int'(dout), 1023);
    check("pin avg128 peak_index", int'(peak_index), 0);

    for (int i = 0; i < RL; i++) rec_data[0][i] = i;
    acquire("ramp_rr", 0, 4, 10, 1, 0);

    for (int i = 0; i < RL; i++) rec_data[0][i] = (i == 5 || i == 7) ? 9 : 2;
    acquire("tie", 0, 0, 15, 1, 0);
    check("pin tie peak_index", int'(peak_index), 5);
    check("pin tie peak_value", int'(peak_value), 9);
    acquire("empty_gate", 0, 12, 3, 0, 0);
    check("pin empty peak_hit", int'(peak_hit), 0);
    check("pin empty peak_value", int'(peak_value), 0);

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < RL; i++) rec_data[r][i] = int'($urandom_range(0, 1023));
    acquire("rand_avg2", 1, 2, 13, 1, 1);

    // clr in the middle of DUMP
    for (int i = 0; i < RL; i++) rec_data[0][i] = 15 - i;
    pulse_arm(0, 0, 15);
    send_rec(0, 0);
    repeat (5) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check("clr busy", int'(busy), 0);
    check("clr dout_valid", int'(dout_valid), 0);
    check("clr done", int'(done), 0);
    check("clr peak_hit", int'(peak_hit), 0);
    check("clr state", int'(state_dbg), int'(IDLE));

    // clr beats arm
    clr = 1'b1; arm = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0; arm = 1'b0;
    check("clr_arm busy", int'(busy), 0);

    // reset mid-ACQ
    pulse_arm(0, 0, 15);
    for (int i = 0; i < 8; i++) begin
      din = DW'(i * 7); din_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_acq busy", int'(busy), 0);
    check("rst_acq dout_valid", int'(dout_valid), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < RL; i++) rec_data[r][i] = int'($urandom_range(0, 1023));
    acquire("rearm", 1, 0, 15, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
